// File: rtl/uart_tx_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_drain
// Description : UART transmitter that pops bytes from a fall-through FIFO
//               read port and serialises them LSB-first on tx at a fixed
//               baud. Frames: START, 8 DATA, optional PARITY, STOP_BITS STOP.
//               Back-to-back frames are sent with no idle gap. tx_hold
//               blocks new frames but never truncates the current one.
// Config      : `define UART_TX_PARITY_EN adds an even-parity bit after DATA.
// Ports       : clk          - system clock, all logic on posedge
//               rst          - synchronous active-high reset
//               fifo_empty   - FIFO empty flag
//               fifo_rd_data - FIFO head byte (valid while !fifo_empty)
//               fifo_rd_en   - one-cycle pop strobe to the FIFO
//               tx_hold      - 1 = do not start new frames
//               tx           - serial line, idle high
//               busy         - 1 from first START cycle to last STOP cycle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo_drain #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rd_data,
  output logic       fifo_rd_en,
  input  logic       tx_hold,
  output logic       tx,
  output logic       busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd4;
`endif

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [CNT_W-1:0] baud_cnt;
  logic [CNT_W-1:0] baud_cnt_next;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_next;
  logic [7:0]       shreg;
  logic             tx_q;
  logic             tx_d;
  logic             pop;

  logic last_tick;
  logic start_ok;
  logic frame_end;

  assign last_tick = (baud_cnt == BAUD_LAST);
  assign start_ok  = !fifo_empty && !tx_hold;
  // Final cycle of the last stop bit: the back-to-back launch point.
  assign frame_end = (state == ST_STOP) && last_tick && (bit_idx == STOP_LAST);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start_ok) state_next = ST_START;
      end
      ST_START: begin
        if (last_tick) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (last_tick && (bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_next = ST_PARITY;
`else
          state_next = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (last_tick) state_next = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (frame_end) state_next = start_ok ? ST_START : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Baud and bit counters restart on every state change; while a timed state
  // persists the baud count wraps and the bit index advances on the wrap.
  always_comb begin
    baud_cnt_next = '0;
    bit_idx_next  = '0;
    if ((state_next != ST_IDLE) && (state_next == state)) begin
      baud_cnt_next = last_tick ? '0 : baud_cnt + CNT_W'(1);
      bit_idx_next  = last_tick ? bit_idx + 3'd1 : bit_idx;
    end
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    // Pop only on a frame-start decision; gated by rst so a reset cycle never
    // consumes a byte.
    pop  = !rst && start_ok && ((state == ST_IDLE) || frame_end);
    // Line value for the coming cycle, registered into tx_q.
    tx_d = 1'b1;
    case (state_next)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shreg[bit_idx_next];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = ^shreg;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx_q     <= 1'b1;
    end else begin
      baud_cnt <= baud_cnt_next;
      bit_idx  <= bit_idx_next;
      tx_q     <= tx_d;
      if (pop) shreg <= fifo_rd_data;
    end
  end

  assign fifo_rd_en = pop;
  assign tx         = tx_q;
  assign busy       = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo_drain
// Description : Self-checking bench for uart_tx_fifo_drain with
//               CLKS_PER_BIT=4, STOP_BITS=1. Table of single-byte frames plus
//               directed sequences for back-to-back, hold and mid-frame reset.
//               Honours `define UART_TX_PARITY_EN (11-bit frames).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo_drain;

  localparam int CPB = 4;
  localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
  localparam int NB  = 11;
`else
  localparam int NB  = 10;
`endif
  localparam int FRAME_CYC = NB * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rd_data = 8'h00;
  logic       fifo_rd_en;
  logic       tx_hold = 1'b0;
  logic       tx;
  logic       busy;

  uart_tx_fifo_drain #(
    .CLKS_PER_BIT (CPB),
    .STOP_BITS    (SB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .tx_hold      (tx_hold),
    .tx           (tx),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;  // hand-written line bits, bit i = i-th bit sent (no parity)
    logic       par;   // hand-computed even parity
  } vec_t;

  vec_t vecs [7];
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;
  logic [7:0] q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to the next negedge; a pop strobe seen before the edge removes the
  // FIFO head, and the new head is presented away from the active edge.
  task automatic tick();
    logic pend;
    pend = fifo_rd_en;
    @(negedge clk);
    if (pend) begin
      pops++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL pop_when_empty: got rd_en 1 expected 0");
      end else begin
        void'(q.pop_front());
      end
      fifo_empty   = (q.size() == 0);
      fifo_rd_data = (q.size() != 0) ? q[0] : 8'h00;
    end
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    fifo_empty   = 1'b0;
    fifo_rd_data = q[0];
    #1;
  endtask

  function automatic logic [10:0] mkseq(input logic [9:0] line, input logic par);
`ifdef UART_TX_PARITY_EN
    return {1'b1, par, line[8:0]};
`else
    return {par & 1'b0, line};
`endif
  endfunction

  // Checks one frame starting at its first START cycle. Each line bit is
  // compared as {tx,busy,rd_en} over its CPB cycles; the first bad cycle is
  // reported. Optionally asserts hold and queues a byte at frame cycle hold_at.
  task automatic check_frame(input string name, input logic [10:0] seq,
                             input logic pop_at_end, input int hold_at,
                             input logic [7:0] hold_byte);
    logic [2:0] act, exp, a_keep, e_keep;
    logic       bad;
    for (int b = 0; b < NB; b++) begin
      bad    = 1'b0;
      a_keep = 3'b000;
      e_keep = 3'b000;
      for (int c = 0; c < CPB; c++) begin
        act = {tx, busy, fifo_rd_en};
        exp = {seq[b], 1'b1, ((b * CPB + c) == FRAME_CYC - 1) ? pop_at_end : 1'b0};
        if (c == 0 || (!bad && act !== exp)) begin
          a_keep = act;
          e_keep = exp;
          bad    = (act !== exp);
        end
        if ((b * CPB + c) == hold_at) begin
          tx_hold = 1'b1;
          push(hold_byte);
        end
        tick();
      end
      check($sformatf("%s bit%0d {tx,busy,rd_en}", name, b), 32'(a_keep), 32'(e_keep));
    end
  endtask

  task automatic check_idle(input string name, input int n);
    logic [2:0] act, a_keep;
    logic       bad;
    bad    = 1'b0;
    a_keep = 3'b100;
    for (int i = 0; i < n; i++) begin
      act = {tx, busy, fifo_rd_en};
      if (!bad && act !== 3'b100) begin
        a_keep = act;
        bad    = 1'b1;
      end
      tick();
    end
    check($sformatf("%s {tx,busy,rd_en}", name), 32'(a_keep), 32'(3'b100));
  endtask

  initial begin
    int p0;
    vecs[0] = '{8'hA5, 10'b1101001010, 1'b0};
    vecs[1] = '{8'h07, 10'b1000001110, 1'b1};
    vecs[2] = '{8'h3C, 10'b1001111000, 1'b0};
    vecs[3] = '{8'h80, 10'b1100000000, 1'b1};
    vecs[4] = '{8'h00, 10'b1000000000, 1'b0};
    vecs[5] = '{8'hFF, 10'b1111111110, 1'b0};
    vecs[6] = '{8'h5A, 10'b1010110100, 1'b0};

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("reset {tx,busy,rd_en}", 32'({tx, busy, fifo_rd_en}), 32'(3'b100));
    rst = 1'b0;
    #1;

    // Empty FIFO: line stays idle
    check_idle("empty_idle", 20);

    // Single frames from the table
    for (int v = 0; v < 7; v++) begin
      p0 = pops;
      push(vecs[v].data);
      check($sformatf("pop_strobe %02h", vecs[v].data), 32'(fifo_rd_en), 32'd1);
      tick();
      check_frame($sformatf("frame %02h", vecs[v].data), mkseq(vecs[v].line, vecs[v].par),
                  1'b0, -1, 8'h00);
      check($sformatf("pop_count %02h", vecs[v].data), 32'(pops - p0), 32'd1);
      check_idle($sformatf("after %02h", vecs[v].data), 3);
    end

    // Back-to-back: 0x00 then 0xFF with no idle cycle between
    p0 = pops;
    push(8'h00);
    push(8'hFF);
    check("b2b pop_strobe", 32'(fifo_rd_en), 32'd1);
    tick();
    check_frame("b2b first", mkseq(10'b1000000000, 1'b0), 1'b1, -1, 8'h00);
    check_frame("b2b second", mkseq(10'b1111111110, 1'b0), 1'b0, -1, 8'h00);
    check("b2b pop_count", 32'(pops - p0), 32'd2);
    check_idle("after b2b", 3);

    // Hold raised at cycle 10 with a byte queued: frame completes, no pop
    p0 = pops;
    push(8'hA5);
    check("hold pop_strobe", 32'(fifo_rd_en), 32'd1);
    tick();
    check_frame("hold frame", mkseq(10'b1101001010, 1'b0), 1'b0, 10, 8'h3C);
    check_idle("held", 8);
    check("held queue depth", 32'(q.size()), 32'd1);
    tx_hold = 1'b0;
    #1;
    check("release pop_strobe", 32'(fifo_rd_en), 32'd1);
    tick();
    check_frame("released frame", mkseq(10'b1001111000, 1'b0), 1'b0, -1, 8'h00);
    check("hold pop_count", 32'(pops - p0), 32'd2);
    check_idle("after release", 3);

    // Reset at cycle 15 of a frame
    push(8'h00);
    check("rstmid pop_strobe", 32'(fifo_rd_en), 32'd1);
    tick();
    repeat (15) tick();
    check("rstmid pre {tx,busy}", 32'({tx, busy}), 32'(2'b01));
    rst = 1'b1;
    #1;
    tick();
    check("rstmid post {tx,busy,rd_en}", 32'({tx, busy, fifo_rd_en}), 32'(3'b100));
    rst = 1'b0;
    #1;
    check_idle("post_reset_idle", 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
